// File: rtl/bcd_updown_counter.sv
// Modulo-MAX_COUNT up/down counter with parallel load and registered BCD view.
// Ticks update count and bcd together using digit-wise BCD ripple; a load
// starts a W-cycle shift-add-3 conversion, during which ticks are dropped.
module bcd_updown_counter #(
  parameter int unsigned MAX_COUNT = 60,
  parameter int unsigned DIGITS    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick_up,
  input  logic                         tick_dn,
  input  logic                         hold,
  input  logic                         load,
  input  logic [$clog2(MAX_COUNT)-1:0] load_val,
  output logic [$clog2(MAX_COUNT)-1:0] count,
  output logic [4*DIGITS-1:0]          bcd,
  output logic                         busy,
  output logic                         carry,
  output logic                         borrow,
  output logic                         load_err,
  output logic                         tick_lost
);

  localparam int unsigned W  = $clog2(MAX_COUNT);
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(W + 1);

  // Elaboration-time BCD of a constant; no divider is built from this.
  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0]  LAST     = W'(MAX_COUNT - 1);
  localparam logic [BW-1:0] BCD_LAST = to_bcd(MAX_COUNT - 1);

  // Digit-wise BCD increment with 9->0 ripple.
  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Digit-wise BCD decrement with 0->9 ripple.
  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  typedef enum logic {RUN, CONV} state_t;

  state_t        state, state_n;
  logic [W-1:0]  count_n;
  logic [BW-1:0] bcd_n;
  logic [W-1:0]  conv_bin, conv_bin_n;
  logic [BW-1:0] conv_acc, conv_acc_n;
  logic [CW-1:0] conv_cnt, conv_cnt_n;
  logic          load_err_n, tick_lost_n;
  logic [BW-1:0] adj, step_acc;
  logic [W-1:0]  load_clamped;

  assign busy         = (state == CONV);
  assign adj          = add3(conv_acc);
  assign step_acc     = {adj[BW-2:0], conv_bin[W-1]};
  assign load_clamped = (load_val > LAST) ? LAST : load_val;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_n;
  end

  // Next-state, datapath next values and the combinational carry/borrow.
  always_comb begin
    state_n     = state;
    count_n     = count;
    bcd_n       = bcd;
    conv_bin_n  = conv_bin;
    conv_acc_n  = conv_acc;
    conv_cnt_n  = conv_cnt;
    load_err_n  = 1'b0;
    tick_lost_n = 1'b0;
    carry       = 1'b0;
    borrow      = 1'b0;
    unique case (state)
      RUN: begin
        if (load) begin
          count_n    = load_clamped;
          load_err_n = (load_val > LAST);
          conv_bin_n = load_clamped;
          conv_acc_n = '0;
          conv_cnt_n = '0;
          state_n    = CONV;
        end else if (!hold && tick_up && !tick_dn) begin
          if (count == LAST) begin
            count_n = '0;
            bcd_n   = '0;
            carry   = 1'b1;
          end else begin
            count_n = count + 1'b1;
            bcd_n   = bcd_inc(bcd);
          end
        end else if (!hold && tick_dn && !tick_up) begin
          if (count == '0) begin
            count_n = LAST;
            bcd_n   = BCD_LAST;
            borrow  = 1'b1;
          end else begin
            count_n = count - 1'b1;
            bcd_n   = bcd_dec(bcd);
          end
        end
      end
      CONV: begin
        tick_lost_n = !hold && (tick_up || tick_dn);
        conv_bin_n  = conv_bin << 1;
        conv_acc_n  = step_acc;
        conv_cnt_n  = conv_cnt + 1'b1;
        // bcd is only written on the last shift so it switches atomically.
        if (conv_cnt == CW'(W - 1)) begin
          bcd_n   = step_acc;
          state_n = RUN;
        end
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count     <= '0;
      bcd       <= '0;
      conv_bin  <= '0;
      conv_acc  <= '0;
      conv_cnt  <= '0;
      load_err  <= 1'b0;
      tick_lost <= 1'b0;
    end else begin
      count     <= count_n;
      bcd       <= bcd_n;
      conv_bin  <= conv_bin_n;
      conv_acc  <= conv_acc_n;
      conv_cnt  <= conv_cnt_n;
      load_err  <= load_err_n;
      tick_lost <= tick_lost_n;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: a MAX_COUNT=60 instance and a
// MAX_COUNT=24 instance. Stimulus pushes hand-computed expectations; a monitor
// on the falling edge pops and compares them.
module tb_bcd_updown_counter;

  logic       clk, rst;
  logic       up_a, dn_a, hold_a, load_a;
  logic [5:0] lv_a, count_a;
  logic [7:0] bcd_a;
  logic       busy_a, carry_a, borrow_a, lerr_a, lost_a;
  logic       up_b, dn_b, hold_b, load_b;
  logic [4:0] lv_b, count_b;
  logic [7:0] bcd_b;
  logic       busy_b, carry_b, borrow_b, lerr_b, lost_b;

  bcd_updown_counter #(.MAX_COUNT(60), .DIGITS(2)) dut_a (
    .clk(clk), .rst(rst), .tick_up(up_a), .tick_dn(dn_a), .hold(hold_a),
    .load(load_a), .load_val(lv_a), .count(count_a), .bcd(bcd_a),
    .busy(busy_a), .carry(carry_a), .borrow(borrow_a),
    .load_err(lerr_a), .tick_lost(lost_a)
  );

  bcd_updown_counter #(.MAX_COUNT(24), .DIGITS(2)) dut_b (
    .clk(clk), .rst(rst), .tick_up(up_b), .tick_dn(dn_b), .hold(hold_b),
    .load(load_b), .load_val(lv_b), .count(count_b), .bcd(bcd_b),
    .busy(busy_b), .carry(carry_b), .borrow(borrow_b),
    .load_err(lerr_b), .tick_lost(lost_b)
  );

  typedef struct {
    bit    dut;
    string name;
    int    cnt;
    int    bcd;
    logic  busy, cy, bw, le, tl;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive inputs just after the rising edge, push what the
  // selected instance must show at the following falling edge.
  task automatic cyc(input bit d, input logic r, up, dn, hd, ld, input int lv,
                     input string nm, input int c, input int b,
                     input logic by, cy, bw, le, tl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    up_a = 1'b0; dn_a = 1'b0; hold_a = 1'b0; load_a = 1'b0; lv_a = '0;
    up_b = 1'b0; dn_b = 1'b0; hold_b = 1'b0; load_b = 1'b0; lv_b = '0;
    if (!d) begin
      up_a = up; dn_a = dn; hold_a = hd; load_a = ld; lv_a = 6'(lv);
    end else begin
      up_b = up; dn_b = dn; hold_b = hd; load_b = ld; lv_b = 5'(lv);
    end
    e.dut = d; e.name = nm; e.cnt = c; e.bcd = b;
    e.busy = by; e.cy = cy; e.bw = bw; e.le = le; e.tl = tl;
    q.push_back(e);
  endtask

  task automatic idle(input bit d, input string nm, input int c, input int b, input logic by);
    cyc(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, nm, c, b, by, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic busy_run(input bit d, input int n, input string nm, input int c, input int b);
    for (int i = 0; i < n; i++) idle(d, nm, c, b, 1'b1);
  endtask

  // Monitor: compare every pending expectation against the addressed instance.
  exp_t e_m;
  int   a_cnt, a_bcd;
  logic a_busy, a_cy, a_bw, a_le, a_tl;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e_m = q.pop_front();
      if (!e_m.dut) begin
        a_cnt = int'(count_a); a_bcd = int'(bcd_a); a_busy = busy_a;
        a_cy = carry_a; a_bw = borrow_a; a_le = lerr_a; a_tl = lost_a;
      end else begin
        a_cnt = int'(count_b); a_bcd = int'(bcd_b); a_busy = busy_b;
        a_cy = carry_b; a_bw = borrow_b; a_le = lerr_b; a_tl = lost_b;
      end
      n_tests++;
      if (a_cnt !== e_m.cnt || a_bcd !== e_m.bcd || a_busy !== e_m.busy ||
          a_cy !== e_m.cy || a_bw !== e_m.bw || a_le !== e_m.le || a_tl !== e_m.tl) begin
        n_fail++;
        $display("FAIL %s: got cnt=%0d bcd=%h busy=%b carry=%b borrow=%b lerr=%b lost=%b; want cnt=%0d bcd=%h busy=%b carry=%b borrow=%b lerr=%b lost=%b",
                 e_m.name, a_cnt, a_bcd[7:0], a_busy, a_cy, a_bw, a_le, a_tl,
                 e_m.cnt, e_m.bcd[7:0], e_m.busy, e_m.cy, e_m.bw, e_m.le, e_m.tl);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    up_a = 1'b0; dn_a = 1'b0; hold_a = 1'b0; load_a = 1'b0; lv_a = '0;
    up_b = 1'b0; dn_b = 1'b0; hold_b = 1'b0; load_b = 1'b0; lv_b = '0;

    // Reset state of both instances.
    cyc(0, 1'b0, 0, 0, 0, 0, 0, "reset_a", 0, 'h00, 0, 0, 0, 0, 0);
    cyc(1, 1'b0, 0, 0, 0, 0, 0, "reset_b", 0, 'h00, 0, 0, 0, 0, 0);

    // Load 58, then two increments: 59, then wrap to 0 with carry.
    cyc(0, 1'b1, 0, 0, 0, 1, 58, "t1_load", 0, 'h00, 0, 0, 0, 0, 0);
    busy_run(0, 6, "t1_conv", 58, 'h00);
    cyc(0, 1'b1, 1, 0, 0, 0, 0, "t1_up1", 58, 'h58, 0, 0, 0, 0, 0);
    cyc(0, 1'b1, 1, 0, 0, 0, 0, "t1_up2", 59, 'h59, 0, 1, 0, 0, 0);
    idle(0, "t1_wrap", 0, 'h00, 0);

    // Decrement from 0 wraps to 59 with borrow; next decrement is plain.
    cyc(0, 1'b1, 0, 1, 0, 0, 0, "t2_dn1", 0, 'h00, 0, 0, 1, 0, 0);
    cyc(0, 1'b1, 0, 1, 0, 0, 0, "t2_dn2", 59, 'h59, 0, 0, 0, 0, 0);
    idle(0, "t2_after", 58, 'h58, 0);

    // Simultaneous strobes cancel; hold freezes; carry only when accepted.
    cyc(0, 1'b1, 1, 0, 0, 0, 0, "t3_up", 58, 'h58, 0, 0, 0, 0, 0);
    cyc(0, 1'b1, 1, 1, 0, 0, 0, "t3_both", 59, 'h59, 0, 0, 0, 0, 0);
    cyc(0, 1'b1, 1, 0, 1, 0, 0, "t3_hold", 59, 'h59, 0, 0, 0, 0, 0);
    idle(0, "t3_chk", 59, 'h59, 0);
    cyc(0, 1'b1, 1, 0, 0, 0, 0, "t3_carry", 59, 'h59, 0, 1, 0, 0, 0);
    idle(0, "t3_wrap", 0, 'h00, 0);

    // Load 42: tick during conversion is lost, hold suppresses the loss
    // pulse, a second load is ignored, bcd switches only at the end.
    cyc(0, 1'b1, 0, 0, 0, 1, 42, "t4_load", 0, 'h00, 0, 0, 0, 0, 0);
    cyc(0, 1'b1, 1, 0, 0, 0, 0, "t4_c1", 42, 'h00, 1, 0, 0, 0, 0);
    idle(0, "t4_c2", 42, 'h00, 1);
    q[$].tl = 1'b1;
    cyc(0, 1'b1, 1, 0, 1, 0, 0, "t4_c3", 42, 'h00, 1, 0, 0, 0, 0);
    cyc(0, 1'b1, 0, 0, 0, 1, 5, "t4_c4", 42, 'h00, 1, 0, 0, 0, 0);
    busy_run(0, 2, "t4_c5", 42, 'h00);
    idle(0, "t4_done", 42, 'h42, 0);

    // Digit ripple across the units/tens boundary.
    cyc(0, 1'b1, 0, 0, 0, 1, 9, "r_load", 42, 'h42, 0, 0, 0, 0, 0);
    busy_run(0, 6, "r_conv", 9, 'h42);
    cyc(0, 1'b1, 1, 0, 0, 0, 0, "r_up", 9, 'h09, 0, 0, 0, 0, 0);
    cyc(0, 1'b1, 0, 1, 0, 0, 0, "r_dn", 10, 'h10, 0, 0, 0, 0, 0);
    idle(0, "r_back", 9, 'h09, 0);

    // Out-of-range loads clamp to 59 with a one-cycle load_err.
    cyc(0, 1'b1, 0, 0, 0, 1, 63, "t5_load", 9, 'h09, 0, 0, 0, 0, 0);
    cyc(0, 1'b1, 0, 0, 0, 0, 0, "t5_err", 59, 'h09, 1, 0, 0, 1, 0);
    busy_run(0, 5, "t5_conv", 59, 'h09);
    idle(0, "t5_done", 59, 'h59, 0);
    cyc(0, 1'b1, 0, 0, 0, 1, 60, "t5b_load", 59, 'h59, 0, 0, 0, 0, 0);
    cyc(0, 1'b1, 0, 0, 0, 0, 0, "t5b_err", 59, 'h59, 1, 0, 0, 1, 0);
    busy_run(0, 5, "t5b_conv", 59, 'h59);
    idle(0, "t5b_done", 59, 'h59, 0);

    // Load 0, no borrow during conversion, reset in conversion cycle 3.
    cyc(0, 1'b1, 0, 0, 0, 1, 0, "t6_load", 59, 'h59, 0, 0, 0, 0, 0);
    cyc(0, 1'b1, 0, 1, 0, 0, 0, "t6_c1", 0, 'h59, 1, 0, 0, 0, 0);
    idle(0, "t6_c2", 0, 'h59, 1);
    q[$].tl = 1'b1;
    cyc(0, 1'b0, 0, 0, 0, 0, 0, "t6_rst", 0, 'h59, 1, 0, 0, 0, 0);
    idle(0, "t6_after", 0, 'h00, 0);
    cyc(0, 1'b1, 1, 0, 0, 0, 0, "t6_up", 0, 'h00, 0, 0, 0, 0, 0);
    idle(0, "t6_run", 1, 'h01, 0);

    // MAX_COUNT=24 instance: 5-cycle conversion, 23<->0 wraps, clamp at 24.
    cyc(1, 1'b1, 0, 0, 0, 1, 22, "b_load", 0, 'h00, 0, 0, 0, 0, 0);
    busy_run(1, 5, "b_conv", 22, 'h00);
    cyc(1, 1'b1, 1, 0, 0, 0, 0, "b_up1", 22, 'h22, 0, 0, 0, 0, 0);
    cyc(1, 1'b1, 1, 0, 0, 0, 0, "b_up2", 23, 'h23, 0, 1, 0, 0, 0);
    cyc(1, 1'b1, 0, 1, 0, 0, 0, "b_dn", 0, 'h00, 0, 0, 1, 0, 0);
    idle(1, "b_wrapdn", 23, 'h23, 0);
    cyc(1, 1'b1, 0, 0, 0, 1, 24, "b_load24", 23, 'h23, 0, 0, 0, 0, 0);
    cyc(1, 1'b1, 0, 0, 0, 0, 0, "b_err", 23, 'h23, 1, 0, 0, 1, 0);
    busy_run(1, 4, "b_conv24", 23, 'h23);
    idle(1, "b_done", 23, 'h23, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
